uart_tx_serializer: RTL
=======================

// Module: uart_tx_serializer
//
// PURPOSE
//   Transmit side of an asynchronous serial link driven out of a single io_out pin.
//   Accepts a parallel byte on a valid/ready handshake and shifts it out LSB-first.
//   Frame: start bit, data bits, optional parity bit, stop bit(s).
//   Instantiated under the top-level wrapper. Its tx output maps to one io_out bit.
//
// PARAMETERS
//   CLKS_PER_BIT  4  clk cycles per serial bit; legal range >= 1
//   DATA_BITS     8  data bits per frame; legal range 1..16
//   STOP_BITS     1  stop bits per frame; 1 or 2
//
// PORTS
//   clk       in   1          single clock; all state on rising edge
//   reset     in   1          asynchronous, active-high reset
//   tx_data   in   DATA_BITS  byte to send; sampled only on accept
//   tx_valid  in   1          producer has data
//   tx_ready  out  1          block can accept; high only in IDLE
//   tx        out  1          serial line, registered; idle level 1
//   busy      out  1          frame in progress; equals ~tx_ready
//
// BEHAVIOUR
//   - Reset (async, takes effect immediately, mid-frame included):
//     tx=1, tx_ready=1, busy=0, state=IDLE, counters=0. Any frame in progress is aborted.
//   - States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   - Accept: a rising edge with tx_valid & tx_ready.
//     - tx_data is latched into the shift register.
//     - State goes to START and tx is registered low on that same edge.
//   - Each bit holds exactly CLKS_PER_BIT cycles.
//     - Baud counter width is $clog2(CLKS_PER_BIT), minimum 1 bit.
//     - The counter counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
//   - DATA: bit 0 is sent first.
//     - Bit index runs 0..DATA_BITS-1.
//     - After the last data bit, go to PARITY if enabled, else STOP.
//   - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then IDLE.
//   - Frame length: (1+DATA_BITS+P+STOP_BITS)*CLKS_PER_BIT cycles, with P=1 when parity is enabled.
//   - tx_ready is deasserted from the accept edge until the first IDLE cycle.
//   - Back-to-back: tx_valid held high gives exactly one extra idle-high cycle between frames.
//     - That idle cycle sits after the last stop cycle.
//     - The next start bit begins on the following edge.
//   - Ignored inputs:
//     - tx_valid while busy; no queueing, no error.
//     - tx_data changes after accept.
//   - Simultaneous reset and accept: reset wins; nothing is latched.
//   - CLKS_PER_BIT=1 must work: one cycle per bit, no counter stall.
//   - No combinational path from inputs to tx. tx_ready is decoded from state only.
//
// CONFIGURATION
//   UART_TX_PARITY_EN defined:
//     - PARITY state is compiled in.
//     - One even-parity bit (XOR of the latched data) follows the MSB, for CLKS_PER_BIT cycles.
//   UART_TX_PARITY_EN undefined:
//     - No PARITY state or logic; DATA goes directly to STOP.
//
// TESTING (CLKS_PER_BIT=4, DATA_BITS=8, STOP_BITS=1 unless stated)
//   1. Assert reset mid-idle, then release.
//      -> tx=1, tx_ready=1, busy=0 during and after reset.
//   2. Send 0xA5 with a one-cycle tx_valid.
//      -> tx levels, 4 cycles each: 0, 1,0,1,0,0,1,0,1, 1.
//      -> tx_ready low for 40 cycles.
//   3. UART_TX_PARITY_EN defined; send 0xA5 then 0x01.
//      -> parity bit 0 for 0xA5, 1 for 0x01.
//      -> each frame 44 cycles.
//   4. Hold tx_valid high; send 0x00 then 0xFF.
//      -> second start bit begins exactly 1 cycle after the first frame's stop bit ends.
//   5. Pulse tx_valid with 0x3C while busy; change tx_data mid-frame.
//      -> transmitted byte unchanged.
//      -> no extra frame.
//   6. Assert reset during data bit 3.
//      -> tx=1 before the next edge.
//      -> after release, sending 0x81 yields a correct frame.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: valid/ready byte in, LSB-first frame out on tx.
// Define UART_TX_PARITY_EN to append one even-parity bit after the data MSB.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DATA_BITS - 1);
  localparam logic          STP_MAX = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] sh;
  logic                 bit_end;
`ifdef UART_TX_PARITY_EN
  logic                 par_q;
`endif

  assign bit_end  = (cnt == CNT_MAX);
  assign tx_ready = (state == IDLE);
  assign busy     = ~tx_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      sh       <= '0;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      // baud counter free-runs inside a frame, wraps on every bit boundary
      if (state == IDLE || bit_end) cnt <= '0;
      else                          cnt <= cnt + 1'b1;

      unique case (state)
        IDLE: begin
          if (tx_valid) begin
            sh      <= tx_data;
            state   <= START;
            tx      <= 1'b0;
            bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
            par_q   <= ^tx_data;
`endif
          end
        end
        START: begin
          if (bit_end) begin
            state <= DATA;
            tx    <= sh[0];
            sh    <= sh >> 1;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == IDX_MAX) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              tx    <= par_q;
`else
              state    <= STOP;
              tx       <= 1'b1;
              stop_idx <= 1'b0;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= sh[0];
              sh      <= sh >> 1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state    <= STOP;
            tx       <= 1'b1;
            stop_idx <= 1'b0;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            if (stop_idx == STP_MAX) state <= IDLE;
            else                     stop_idx <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule
